// File: rtl/silife_spi_ctrl.sv
// SPI mode-0 slave bridging the silife control pins to a byte-wide register bus.
// A command byte carries RW in bit 7 and a 7-bit register address. Writes and
// reads auto-increment the address for burst access. All SPI pins are
// asynchronous and are oversampled in the core clock domain.
module silife_spi_ctrl #(
    parameter int ADDR_WIDTH  = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [7:0]            reg_rdata
);

    typedef enum logic [2:0] {
        WAIT_CS_HIGH,
        IDLE,
        CMD,
        WDATA,
        RDATA
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    // Synchronizer chains; the last stage is the usable, metastability-free value.
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;

    logic cs_s;
    logic sck_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  byte_in;
    logic [7:0]  shift_out;
    logic [7:0]  prefetch;
    logic        re_pend;
    logic        cap_pend;
    logic        inc_pend;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;

    // Byte as it will look once the current mosi bit is shifted in.
    assign byte_in  = {shift_in, mosi_s};

    // miso is the MSB of the shift-out register, which is cleared outside reads.
    assign spi_miso = shift_out[7];

    // Control synchronizers are reset; cs resets low so a transfer already in
    // progress is never mistaken for an idle bus right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync  <= '0;
            sck_sync <= '0;
            sck_d    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            sck_d    <= sck_s;
        end
    end

    // Data synchronizer for mosi, no reset needed.
    always_ff @(posedge clk) begin
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end

    // Framing FSM plus the strobe/prefetch pipeline that follows each byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_CS_HIGH;
            bit_cnt     <= 3'd0;
            reg_addr    <= '0;
            reg_wdata   <= 8'h00;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            spi_miso_oe <= 1'b0;
            shift_out   <= 8'h00;
            re_pend     <= 1'b0;
            cap_pend    <= 1'b0;
            inc_pend    <= 1'b0;
        end else begin
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            cap_pend <= reg_re;

            // Address advances the cycle after a write strobe.
            if (inc_pend) begin
                reg_addr <= reg_addr + ADDR_ONE;
                inc_pend <= 1'b0;
            end

            // Read strobe for the next burst byte, one cycle after the increment.
            if (re_pend) begin
                reg_re  <= 1'b1;
                re_pend <= 1'b0;
            end

            // Read data is valid exactly one cycle after the strobe.
            if (cap_pend) begin
                prefetch <= reg_rdata;
            end

            case (state)
                WAIT_CS_HIGH: begin
                    if (cs_s) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (!cs_s) begin
                        bit_cnt <= 3'd0;
                        state   <= CMD;
                    end
                end

                default: begin
                    if (cs_s) begin
                        // Deselect aborts everything; a partial byte is dropped.
                        state       <= IDLE;
                        bit_cnt     <= 3'd0;
                        spi_miso_oe <= 1'b0;
                        shift_out   <= 8'h00;
                        re_pend     <= 1'b0;
                        cap_pend    <= 1'b0;
                        inc_pend    <= 1'b0;
                    end else if (sck_rise) begin
                        shift_in <= byte_in[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == CMD) begin
                                reg_addr <= byte_in[ADDR_WIDTH-1:0];
                                if (byte_in[7]) begin
                                    state <= WDATA;
                                end else begin
                                    reg_re      <= 1'b1;
                                    spi_miso_oe <= 1'b1;
                                    state       <= RDATA;
                                end
                            end else if (state == WDATA) begin
                                reg_wdata <= byte_in;
                                reg_we    <= 1'b1;
                                inc_pend  <= 1'b1;
                            end else begin
                                reg_addr <= reg_addr + ADDR_ONE;
                                re_pend  <= 1'b1;
                            end
                        end
                    end else if (sck_fall && state == RDATA) begin
                        // The fall that opens a new byte loads the prefetched data.
                        if (bit_cnt == 3'd0) begin
                            shift_out <= prefetch;
                        end else begin
                            shift_out <= {shift_out[6:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_silife_spi_ctrl.sv
// Testbench for silife_spi_ctrl: table-driven SPI transactions, a write
// scoreboard, a register-file read model and hand-written abort/reset cases.
module tb_silife_spi_ctrl;

    logic       clk;
    logic       reset;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    logic we_prev = 1'b0;
    logic re_prev = 1'b0;

    logic [14:0] wq[$];

    typedef struct packed {
        bit              wr;
        logic [6:0]      addr;
        int              n;
        logic [2:0][7:0] d;
        logic [2:0][6:0] ea;
        logic [2:0][7:0] ed;
    } vec_t;

    vec_t vecs[6];

    silife_spi_ctrl #(.ADDR_WIDTH(7), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file read model: data = addr ^ 0x5A, one clock after reg_re.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= {1'b0, reg_addr} ^ 8'h5A;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe monitor and write scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (reg_we && reg_re) chk("we_re_overlap", 1, 0);
        if (reg_we && we_prev) chk("we_width", 2, 1);
        if (reg_re && re_prev) chk("re_width", 2, 1);
        if (reg_we) begin
            we_cnt++;
            if (wq.size() == 0) begin
                chk("we_unexpected", {17'd0, reg_addr, reg_wdata}, 32'hFFFF_FFFF);
            end else begin
                chk("we_addr_data", {17'd0, reg_addr, reg_wdata}, {17'd0, wq.pop_front()});
            end
        end
        if (reg_re) re_cnt++;
        we_prev <= reg_we;
        re_prev <= reg_re;
    end

    function automatic vec_t mk(bit wr, logic [6:0] a, int n, logic [23:0] d,
                                logic [20:0] ea, logic [23:0] ed);
        vec_t v;
        v.wr = wr; v.addr = a; v.n = n; v.d = d; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic xfer_bit(input logic b, input int ph, output logic m);
        spi_mosi = b;
        #(ph * 10);
        m = spi_miso;
        spi_sck = 1'b1;
        #(ph * 10);
        spi_sck = 1'b0;
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nb, input int ph, output logic [7:0] rx);
        logic b;
        rx = 8'h00;
        for (int i = 7; i >= 8 - nb; i--) begin
            xfer_bit(tx[i], ph, b);
            rx[i] = b;
        end
    endtask

    task automatic run_txn(input vec_t v, input int ph, input int off);
        int we0, re0;
        logic [7:0] rx;
        we0 = we_cnt;
        re0 = re_cnt;
        @(posedge clk);
        #(off);
        spi_cs_n = 1'b0;
        #(ph * 10);
        xfer_bits({v.wr, v.addr}, 8, ph, rx);
        if (v.wr) chk("oe_after_wcmd", spi_miso_oe, 0);
        for (int i = 0; i < v.n; i++) begin
            if (v.wr) wq.push_back({v.ea[i], v.ed[i]});
            xfer_bits(v.wr ? v.d[i] : 8'h00, 8, ph, rx);
            if (!v.wr) begin
                chk("rd_byte", rx, v.ed[i]);
                chk("oe_rdata", spi_miso_oe, 1);
            end
        end
        #(ph * 10);
        spi_cs_n = 1'b1;
        #(ph * 30);
        chk("wq_drained", wq.size(), 0);
        chk("we_count", we_cnt - we0, v.wr ? v.n : 0);
        chk("re_count", re_cnt - re0, v.wr ? 0 : v.n + 1);
        chk("idle_miso_oe", {spi_miso, spi_miso_oe}, 0);
    endtask

    initial begin
        vec_t rv;
        logic [7:0] rx;
        int we0;

        vecs[0] = mk(1, 7'h05, 1, 24'h0000A5, {7'h00, 7'h00, 7'h05}, 24'h0000A5);
        vecs[1] = mk(1, 7'h7F, 3, 24'h332211, {7'h01, 7'h00, 7'h7F}, 24'h332211);
        vecs[2] = mk(0, 7'h10, 2, 24'h000000, {7'h00, 7'h11, 7'h10}, 24'h004B4A);
        vecs[3] = mk(0, 7'h7F, 2, 24'h000000, {7'h00, 7'h00, 7'h7F}, 24'h005A25);
        vecs[4] = mk(1, 7'h02, 1, 24'h00003C, {7'h00, 7'h00, 7'h02}, 24'h00003C);
        vecs[5] = mk(1, 7'h05, 1, 24'h00005E, {7'h00, 7'h00, 7'h05}, 24'h00005E);

        reset = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        reg_rdata = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_outs", {reg_addr, reg_wdata, reg_we, reg_re, spi_miso, spi_miso_oe}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);

        for (int i = 0; i < 4; i++) run_txn(vecs[i], 5, 3);

        // Partial byte abort: 5 data bits then deselect.
        we0 = we_cnt;
        @(posedge clk); #3;
        spi_cs_n = 1'b0;
        #50;
        xfer_bits(8'h82, 8, 5, rx);
        xfer_bits(8'hF0, 5, 5, rx);
        #50;
        spi_cs_n = 1'b1;
        #200;
        chk("abort_no_we", we_cnt - we0, 0);
        chk("abort_oe", spi_miso_oe, 0);
        run_txn(vecs[4], 5, 3);

        // Reset after 12 bits of a write, then 8 more bits with cs still low.
        we0 = we_cnt;
        @(posedge clk); #3;
        spi_cs_n = 1'b0;
        #50;
        xfer_bits(8'h85, 8, 5, rx);
        xfer_bits(8'hC0, 4, 5, rx);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("midrst_outs", {reg_addr, reg_wdata, reg_we, reg_re, spi_miso, spi_miso_oe}, 0);
        xfer_bits(8'hAA, 8, 5, rx);
        #100;
        chk("midrst_no_we", we_cnt - we0, 0);
        chk("midrst_outs_after", {reg_addr, reg_wdata, reg_we, reg_re, spi_miso, spi_miso_oe}, 0);
        spi_cs_n = 1'b1;
        #200;
        run_txn(vecs[5], 5, 3);

        // Minimum 4-clk sck phases with random alignment to clk.
        for (int t = 0; t < 200; t++) begin
            rv.wr   = 1'($urandom_range(0, 1));
            rv.addr = 7'($urandom_range(0, 127));
            rv.n    = $urandom_range(1, 2);
            rv.d    = 24'($urandom);
            for (int i = 0; i < 3; i++) begin
                rv.ea[i] = rv.addr + 7'(i);
                rv.ed[i] = rv.wr ? rv.d[i] : ({1'b0, rv.ea[i]} ^ 8'h5A);
            end
            run_txn(rv, 4, $urandom_range(1, 9));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
